pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the RISC-V core. It holds the architectural PC and presents it to instruction memory through a valid/ready fetch handshake. On each accepted fetch it advances the PC to either PC+4 or the branch/jump target computed by the datapath's target adder. It also counts retired fetches and, when the trap feature is compiled in, redirects misaligned targets to a trap vector.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on a misaligned-target trap.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- PCSrc  input  1  1 = next PC is PCTarget, 0 = next PC is PC+4.
- PCTarget  input  32  branch/jump target from the datapath target adder.
- stall  input  1  hazard hold; freezes PC and counter.
- fetch_ready  input  1  instruction memory accepts the current PC.
- trap_clr  input  1  one-cycle pulse that acknowledges a trap.
- PC  output  32  current fetch address (registered).
- PCPlus4  output  32  PC + 4, combinational, modulo 2^32.
- fetch_valid  output  1  PC is a valid fetch request.
- trap  output  1  trap pending (sticky until trap_clr).
- trap_addr  output  32  offending PCTarget captured at trap entry.
- retire_cnt  output  32  number of accepted fetches.

## Operation
- States: BOOT, FETCH, TRAP.
- Reset values (asynchronous, while rst_n=0):
  - state=BOOT, PC=RESET_VECTOR, fetch_valid=0.
  - trap=0, trap_addr=0, retire_cnt=0.
- BOOT: fetch_valid=0 for exactly one cycle after rst_n rises, then go to FETCH. PC is unchanged.
- FETCH: fetch_valid=1. A fetch is accepted when fetch_valid & fetch_ready & !stall. On acceptance:
  - retire_cnt increments by 1, wrapping 0xFFFF_FFFF -> 0.
  - PC loads PCTarget if PCSrc=1, otherwise PCPlus4.
- Misaligned target: an accepted fetch with PCSrc=1 and PCTarget[1:0]!=0 (trap build only):
  - PC loads TRAP_VECTOR; trap_addr loads PCTarget; trap=1; state goes to TRAP.
  - retire_cnt still increments, because the fetch is retired.
- TRAP: fetch_valid=0 and PC is held. trap_clr=1 clears trap and returns to FETCH, with the next fetch at TRAP_VECTOR.
- Ignored inputs:
  - trap_clr is ignored in BOOT and FETCH.
  - stall and fetch_ready are ignored in TRAP.
- Arithmetic:
  - All adds are 32-bit modulo; PC 0xFFFF_FFFC advances to 0x0000_0000.
  - PCSrc is sampled only at acceptance; it is not latched.

## Timing
- Latency: PC changes on the first rising edge after an accepted fetch. There is no bubble between back-to-back fetches: one fetch per cycle when fetch_ready=1 and stall=0.
- stall has priority over fetch_ready. While stalled, fetch_valid stays 1 and PC stays stable. A PCSrc/PCTarget presented during a stall has no effect unless it is held until acceptance.
- fetch_valid=1 with fetch_ready=0: PC, fetch_valid and retire_cnt hold (standard valid/ready; PC never changes while valid is pending).
- trap rises on the edge that accepts the offending fetch. fetch_valid falls on the same edge. trap falls on the edge sampling trap_clr=1. fetch_valid=1 from the following cycle.
- Reset asserted mid-operation, including in TRAP: all outputs return to reset values immediately (asynchronous). Exit is through BOOT.

## Configuration
- MISALIGN_TRAP_EN defined:
  - TRAP state, trap, trap_addr and TRAP_VECTOR behave as above.
- MISALIGN_TRAP_EN undefined:
  - No TRAP state; trap and trap_addr are tied to 0; trap_clr is ignored.
  - Targets load with PCTarget[1:0] forced to 2'b00, so 0x0000_0046 loads as 0x0000_0044.

## Test plan
- Reset then release; fetch_ready=1, PCSrc=0 for 4 cycles -> one cycle fetch_valid=0, then PC = 0x0, 0x4, 0x8, 0xC, and retire_cnt=4.
- PC=0x10, PCSrc=1, PCTarget=0x200, fetch_ready=1 -> PC=0x200 next cycle, then 0x204.
- stall=1 for 3 cycles with fetch_ready=1 at PC=0x8 -> PC stays 0x8 and retire_cnt holds; PC=0xC the cycle after stall drops.
- PC=0xFFFF_FFFC accepted with PCSrc=0 -> PC=0x0 and PCPlus4=0x4.
- Misaligned target, MISALIGN_TRAP_EN defined: PCSrc=1, PCTarget=0x0000_0046 accepted -> trap=1, trap_addr=0x46, PC=0x100, fetch_valid=0.
  - Then trap_clr pulse -> trap=0 and fetch resumes at 0x100.
  - Without the macro, the same stimulus -> PC=0x44 and trap stays 0.
- rst_n pulled low while in TRAP -> PC=RESET_VECTOR, trap=0 and retire_cnt=0 immediately; a BOOT cycle follows release.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC with valid/ready fetch handshake,
// retire counter and optional misaligned-target trap.
//
// Build option: define MISALIGN_TRAP_EN to enable the TRAP state,
// trap/trap_addr outputs and the redirect to TRAP_VECTOR.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   PCSrc            1: next PC = PCTarget, 0: next PC = PC+4
//   PCTarget         branch/jump target
//   stall            hazard hold (beats fetch_ready)
//   fetch_ready      imem accepts PC
//   trap_clr         trap acknowledge pulse
//   PC, PCPlus4      current PC and PC+4
//   fetch_valid      PC is a valid fetch request
//   trap, trap_addr  sticky trap flag and offending target
//   retire_cnt       accepted fetch count
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic        trap_clr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        fetch_valid,
  output logic        trap,
  output logic [31:0] trap_addr,
  output logic [31:0] retire_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] nxt_tgt;
  logic [31:0] nxt_pc;
  logic        accept;

  assign PCPlus4 = PC + 32'd4;
  assign accept  = fetch_ready & ~stall;

`ifdef MISALIGN_TRAP_EN
  logic misalign;

  assign misalign = PCSrc & (PCTarget[1:0] != 2'b00);
  assign nxt_tgt  = PCTarget;
`else
  // Without the trap, low target bits are simply dropped.
  logic unused_in;

  assign nxt_tgt   = {PCTarget[31:2], 2'b00};
  assign unused_in = ^{trap_clr, PCTarget[1:0]};
  assign trap      = 1'b0;
  assign trap_addr = 32'h0;
`endif

  assign nxt_pc = PCSrc ? nxt_tgt : PCPlus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      PC          <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      retire_cnt  <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      trap        <= 1'b0;
      trap_addr   <= 32'h0;
`endif
    end else begin
      unique case (state)
        BOOT: begin
          state       <= FETCH;
          fetch_valid <= 1'b1;
        end
        FETCH: begin
          if (accept) begin
            retire_cnt <= retire_cnt + 32'd1;
`ifdef MISALIGN_TRAP_EN
            if (misalign) begin
              // Fetch still retires; PC parks at the vector.
              PC          <= TRAP_VECTOR;
              trap_addr   <= PCTarget;
              trap        <= 1'b1;
              fetch_valid <= 1'b0;
              state       <= TRAP;
            end else begin
              PC <= nxt_pc;
            end
`else
            PC <= nxt_pc;
`endif
          end
        end
        TRAP: begin
`ifdef MISALIGN_TRAP_EN
          if (trap_clr) begin
            trap        <= 1'b0;
            fetch_valid <= 1'b1;
            state       <= FETCH;
          end
`else
          fetch_valid <= 1'b1;
          state       <= FETCH;
`endif
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, reset-in-trap sequence
// and randomized run against a behavioural PC model.
module tb_pc_sequencer;

`ifdef MISALIGN_TRAP_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif
  localparam logic [31:0] TVEC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        stall;
  logic        fetch_ready;
  logic        trap_clr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        fetch_valid;
  logic        trap;
  logic [31:0] trap_addr;
  logic [31:0] retire_cnt;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget),
    .stall       (stall),
    .fetch_ready (fetch_ready),
    .trap_clr    (trap_clr),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .fetch_valid (fetch_valid),
    .trap        (trap),
    .trap_addr   (trap_addr),
    .retire_cnt  (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stl;
    logic        rdy;
    logic        src;
    logic        clr;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_val;
    logic        e_trap;
    logic [31:0] e_taddr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tv[$];

  // behavioural model: architectural state only
  bit          m_boot;
  bit          m_trap;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_taddr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic p,
                       input logic c, input logic [31:0] t);
    stall       = s;
    fetch_ready = r;
    PCSrc       = p;
    trap_clr    = c;
    PCTarget    = t;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".pc"}, PC, 32'h0);
    chk({nm, ".valid"}, {31'b0, fetch_valid}, 32'h0);
    chk({nm, ".trap"}, {31'b0, trap}, 32'h0);
    chk({nm, ".taddr"}, trap_addr, 32'h0);
    chk({nm, ".cnt"}, retire_cnt, 32'h0);
  endtask

  function automatic vec_t mk(input logic s, input logic r,
                              input logic p, input logic c,
                              input logic [31:0] t,
                              input logic [31:0] pc, input logic v,
                              input logic tr, input logic [31:0] ta,
                              input logic [31:0] n);
    vec_t x;
    x.stl = s; x.rdy = r; x.src = p; x.clr = c; x.tgt = t;
    x.e_pc = pc; x.e_val = v; x.e_trap = tr;
    x.e_taddr = ta; x.e_cnt = n;
    return x;
  endfunction

  function automatic void model_reset();
    m_boot  = 1'b1;
    m_trap  = 1'b0;
    m_pc    = 32'h0;
    m_cnt   = 32'h0;
    m_taddr = 32'h0;
  endfunction

  // One clock of the architectural rules for the sampled inputs.
  function automatic void model_step(input logic s, input logic r,
                                     input logic p, input logic c,
                                     input logic [31:0] t);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_trap) begin
      if (c) m_trap = 1'b0;
    end else if (r && !s) begin
      m_cnt = m_cnt + 1;
      if (p && TE && (t % 4 != 0)) begin
        m_trap  = 1'b1;
        m_taddr = t;
        m_pc    = TVEC;
      end else if (p) begin
        m_pc = t - (t % 4);
      end else begin
        m_pc = m_pc + 4;
      end
    end
  endfunction

  task automatic chk_model(input string nm);
    chk({nm, ".pc"}, PC, m_pc);
    chk({nm, ".pc4"}, PCPlus4, m_pc + 32'd4);
    chk({nm, ".valid"}, {31'b0, fetch_valid},
        {31'b0, !m_boot && !m_trap});
    chk({nm, ".trap"}, {31'b0, trap}, {31'b0, m_trap});
    chk({nm, ".taddr"}, trap_addr, m_taddr);
    chk({nm, ".cnt"}, retire_cnt, m_cnt);
  endtask

  task automatic async_reset(input string nm);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals(nm);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals({nm, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    logic s, r, p, c;
    logic [31:0] t;

    drive(0, 0, 0, 0, 32'h0);
    rst_n = 1'b0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("boot.valid", {31'b0, fetch_valid}, 32'h0);

    tv.push_back(mk(0,1,0,0,32'h0,   32'h0,  1,0,0,0));
    tv.push_back(mk(0,1,0,0,32'h0,   32'h4,  1,0,0,1));
    tv.push_back(mk(0,1,0,0,32'h0,   32'h8,  1,0,0,2));
    tv.push_back(mk(1,1,1,0,32'h300, 32'h8,  1,0,0,2));
    tv.push_back(mk(1,1,1,0,32'h300, 32'h8,  1,0,0,2));
    tv.push_back(mk(1,1,1,0,32'h300, 32'h8,  1,0,0,2));
    tv.push_back(mk(0,1,0,0,32'h0,   32'hC,  1,0,0,3));
    tv.push_back(mk(0,1,0,0,32'h0,   32'h10, 1,0,0,4));
    tv.push_back(mk(0,1,1,0,32'h200, 32'h200,1,0,0,5));
    tv.push_back(mk(0,0,1,0,32'h500, 32'h200,1,0,0,5));
    tv.push_back(mk(0,1,0,0,32'h0,   32'h204,1,0,0,6));
    tv.push_back(mk(0,1,1,0,32'h46,  TE ? TVEC : 32'h44, !TE, TE,
                    TE ? 32'h46 : 32'h0, 7));
    tv.push_back(mk(0,1,0,0,32'h0,   TE ? TVEC : 32'h48, !TE, TE,
                    TE ? 32'h46 : 32'h0, TE ? 7 : 8));
    tv.push_back(mk(0,0,0,1,32'h0,   TE ? TVEC : 32'h48, 1, 0,
                    TE ? 32'h46 : 32'h0, TE ? 7 : 8));
    tv.push_back(mk(0,1,0,0,32'h0,   TE ? 32'h104 : 32'h4C, 1, 0,
                    TE ? 32'h46 : 32'h0, TE ? 8 : 9));
    tv.push_back(mk(0,1,1,0,32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0,
                    TE ? 32'h46 : 32'h0, TE ? 9 : 10));
    tv.push_back(mk(0,1,0,0,32'h0,   32'h0, 1, 0,
                    TE ? 32'h46 : 32'h0, TE ? 10 : 11));

    foreach (tv[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      drive(tv[i].stl, tv[i].rdy, tv[i].src, tv[i].clr, tv[i].tgt);
      step();
      chk({nm, ".pc"}, PC, tv[i].e_pc);
      chk({nm, ".pc4"}, PCPlus4, tv[i].e_pc + 32'd4);
      chk({nm, ".valid"}, {31'b0, fetch_valid}, {31'b0, tv[i].e_val});
      chk({nm, ".trap"}, {31'b0, trap}, {31'b0, tv[i].e_trap});
      chk({nm, ".taddr"}, trap_addr, tv[i].e_taddr);
      chk({nm, ".cnt"}, retire_cnt, tv[i].e_cnt);
    end

    // misaligned jump, then reset while (possibly) trapped
    drive(0, 1, 1, 0, 32'h0000_0006);
    step();
    chk("mis.trap", {31'b0, trap}, {31'b0, TE});
    chk("mis.pc", PC, TE ? TVEC : 32'h4);
    async_reset("trst");
    drive(0, 1, 0, 1, 32'h0);
    #1 chk("trst.boot", {31'b0, fetch_valid}, 32'h0);
    step();
    chk("trst.fetch", {31'b0, fetch_valid}, 32'h1);
    chk("trst.pc", PC, 32'h0);

    // randomized run against the model
    async_reset("rrst");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset("mid");
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) < 7);
      p = $urandom_range(0, 1);
      c = ($urandom_range(0, 4) == 0);
      t = $urandom;
      if ($urandom_range(0, 4) != 0) t[1:0] = 2'b00;
      drive(s, r, p, c, t);
      step();
      model_step(s, r, p, c, t);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
